// File: rtl/bus_trace_probe.sv
// rtl/bus_trace_probe.sv - bus pattern generator with trace FIFO and LED replay
module bus_trace_probe #(
    parameter int          DATA_WIDTH = 16,
    parameter int          DEPTH      = 16,
    parameter int          LED_WIDTH  = 5,
    parameter logic [15:0] SEED       = 16'h5500
) (
    input  logic                       one_shot_clock,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      bus_in,
    input  logic                       drive_req,
    input  logic [1:0]                 mode,
    input  logic                       reload,
    input  logic                       capture_en,
    input  logic                       view_next,
    input  logic                       clear_ovf,
    output logic [DATA_WIDTH-1:0]      bus_out,
    output logic                       bus_oe,
    output logic [DATA_WIDTH-1:0]      view_data,
    output logic [LED_WIDTH-1:0]       leds,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATA_WIDTH-1:0] SEED_W = DATA_WIDTH'(SEED);

    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] view_q, view_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic do_push, do_pop, drop;

    assign bus_out   = pattern_q;
    assign bus_oe    = drive_req;
    assign view_data = view_q;
    assign leds      = view_q[LED_WIDTH-1:0];
    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign overflow  = ovf_q;

    // A pop while full frees the slot the coincident push lands in.
    assign do_pop  = view_next & ~empty;
    assign do_push = capture_en & (~full | do_pop);
    assign drop    = capture_en & full & ~view_next;

    always_comb begin
        pattern_d = pattern_q;
        if (reload) begin
            pattern_d = SEED_W;
        end else if (drive_req) begin
            case (mode)
                2'd0:    pattern_d = pattern_q + DATA_WIDTH'(1);
                2'd1:    pattern_d = pattern_q - DATA_WIDTH'(1);
                2'd2:    pattern_d = {pattern_q[DATA_WIDTH-2:0], pattern_q[DATA_WIDTH-1]};
                default: pattern_d = pattern_q;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        view_d   = view_q;
        ovf_d    = ovf_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            view_d   = mem[rd_ptr_q];
        end
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
        if (clear_ovf) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    always_ff @(posedge one_shot_clock) begin
        if (reset) begin
            pattern_q <= SEED_W;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            view_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            view_q    <= view_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge one_shot_clock) begin
        if (!reset && do_push) mem[wr_ptr_q] <= bus_in;
    end

endmodule

// File: tb/tb_bus_trace_probe.sv
// tb/tb_bus_trace_probe.sv - directed self-checking bench for bus_trace_probe
module tb_bus_trace_probe;

    logic        clk = 1'b0;
    logic        reset;
    logic        drive_req, reload, capture_en, view_next, clear_ovf;
    logic [1:0]  mode;
    logic [15:0] ext_data;
    logic [15:0] bus_in;

    logic [15:0] bus_out, view_data;
    logic        bus_oe, full, empty, overflow;
    logic [4:0]  leds, count;

    logic        alt_drive;
    logic [1:0]  alt_mode;
    logic [15:0] alt_bus_out, alt_view, alt_bus_in;
    logic        alt_oe, alt_full, alt_empty, alt_ovf;
    logic [4:0]  alt_leds, alt_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign bus_in     = bus_oe ? bus_out : ext_data;
    assign alt_bus_in = alt_oe ? alt_bus_out : ext_data;

    bus_trace_probe u_dut (
        .one_shot_clock(clk), .reset(reset), .bus_in(bus_in),
        .drive_req(drive_req), .mode(mode), .reload(reload),
        .capture_en(capture_en), .view_next(view_next), .clear_ovf(clear_ovf),
        .bus_out(bus_out), .bus_oe(bus_oe), .view_data(view_data), .leds(leds),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    bus_trace_probe #(.SEED(16'h8000)) u_alt (
        .one_shot_clock(clk), .reset(reset), .bus_in(alt_bus_in),
        .drive_req(alt_drive), .mode(alt_mode), .reload(1'b0),
        .capture_en(1'b0), .view_next(1'b0), .clear_ovf(1'b0),
        .bus_out(alt_bus_out), .bus_oe(alt_oe), .view_data(alt_view), .leds(alt_leds),
        .count(alt_count), .full(alt_full), .empty(alt_empty), .overflow(alt_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; drive_req = 0; reload = 0; capture_en = 0; view_next = 0;
        clear_ovf = 0; mode = 2'd0; ext_data = 16'h0; alt_drive = 0; alt_mode = 2'd0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_count", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_view", view_data, 16'h0);
        chk("rst_pattern", bus_out, 16'h5500);
        chk("rst_oe", bus_oe, 1'b0);
        chk("rst_alt_pattern", alt_bus_out, 16'h8000);
        chk("rst_alt_count", alt_count, 5'd0);

        // inc mode
        drive_req = 1; mode = 2'd0; #1;
        chk("inc_oe", bus_oe, 1'b1);
        chk("inc0", bus_out, 16'h5500);
        step(); chk("inc1", bus_out, 16'h5501);
        step(); chk("inc2", bus_out, 16'h5502);
        step(); drive_req = 0; #1;
        chk("inc_end", bus_out, 16'h5503);
        chk("oe_off", bus_oe, 1'b0);
        step(); chk("no_drive_hold", bus_out, 16'h5503);

        // rol, dec, hold, inc wrap on the SEED=8000 instance
        do_reset();
        alt_drive = 1; alt_mode = 2'd2; #1;
        chk("rol0", alt_bus_out, 16'h8000);
        step(); chk("rol1", alt_bus_out, 16'h0001);
        step(); chk("rol2", alt_bus_out, 16'h0002);
        alt_mode = 2'd1;
        step(); chk("dec1", alt_bus_out, 16'h0001);
        step(); chk("dec0", alt_bus_out, 16'h0000);
        step(); chk("dec_wrap", alt_bus_out, 16'hFFFF);
        alt_mode = 2'd3;
        step(); chk("hold", alt_bus_out, 16'hFFFF);
        alt_mode = 2'd0;
        step(); chk("inc_wrap", alt_bus_out, 16'h0000);
        alt_drive = 0;

        // capture driven pattern, then replay
        do_reset();
        drive_req = 1; capture_en = 1; mode = 2'd0;
        for (int i = 0; i < 4; i++) step();
        drive_req = 0; capture_en = 0; #1;
        chk("cap_count", count, 5'd4);
        chk("cap_pattern", bus_out, 16'h5504);
        view_next = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("replay_view", view_data, 32'h5500 + i);
            chk("replay_leds", leds, i);
            chk("replay_count", count, 3 - i);
        end
        view_next = 0;
        chk("replay_empty", empty, 1'b1);

        // overflow
        do_reset();
        capture_en = 1;
        for (int i = 0; i < 18; i++) begin
            ext_data = 16'h1000 + 16'(i);
            step();
            if (i == 15) begin
                chk("full_at_16", full, 1'b1);
                chk("no_ovf_at_16", overflow, 1'b0);
            end
        end
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", count, 5'd16);
        clear_ovf = 1; ext_data = 16'h1FFF;
        step();
        chk("ovf_set_wins", overflow, 1'b1);
        capture_en = 0;
        step(); clear_ovf = 0;
        chk("ovf_cleared", overflow, 1'b0);
        view_next = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("ovf_pop", view_data, 32'h1000 + i);
        end
        view_next = 0;
        chk("ovf_drained", empty, 1'b1);

        // push+pop while full, pop while empty
        do_reset();
        capture_en = 1;
        for (int i = 0; i < 16; i++) begin
            ext_data = 16'h2000 + 16'(i);
            step();
        end
        ext_data = 16'h2100; view_next = 1;
        step();
        chk("pp_count", count, 5'd16);
        chk("pp_ovf", overflow, 1'b0);
        chk("pp_view", view_data, 16'h2000);
        chk("pp_full", full, 1'b1);
        capture_en = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("pp_pop", view_data, (i == 16) ? 32'h2100 : 32'h2000 + i);
        end
        step();
        view_next = 0;
        chk("empty_pop_view", view_data, 16'h2100);
        chk("empty_pop_count", count, 5'd0);
        chk("empty_pop_ovf", overflow, 1'b0);

        // push+pop while empty: only push happens
        capture_en = 1; view_next = 1; ext_data = 16'h3333;
        step();
        capture_en = 0; view_next = 0;
        chk("pe_count", count, 5'd1);
        chk("pe_view", view_data, 16'h2100);

        // reset mid-capture
        do_reset();
        capture_en = 1;
        for (int i = 0; i < 3; i++) begin
            ext_data = 16'h4000 + 16'(i);
            step();
        end
        reset = 1;
        step();
        reset = 0; capture_en = 0; view_next = 1;
        step();
        view_next = 0;
        chk("mrst_count", count, 5'd0);
        chk("mrst_empty", empty, 1'b1);
        chk("mrst_view", view_data, 16'h0);
        chk("mrst_pattern", bus_out, 16'h5500);

        // reload beats mode update
        drive_req = 1; mode = 2'd0;
        step(); step();
        chk("pre_reload", bus_out, 16'h5502);
        reload = 1;
        step();
        reload = 0; drive_req = 0; #1;
        chk("reload", bus_out, 16'h5500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
